// File: rtl/noc_pkg.sv
// noc_pkg: shared router constants, port and flit encodings, XY routing.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_XP    = 3'd1,
        PORT_XM    = 3'd2,
        PORT_YP    = 3'd3,
        PORT_YM    = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'b00,
        FLIT_BODY   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_e;

    // Dimension-ordered route: resolve X fully before moving in Y.
    function automatic logic [2:0] xy_route(
        input int unsigned dst_x,
        input int unsigned dst_y,
        input int unsigned cur_x,
        input int unsigned cur_y
    );
        if (dst_x > cur_x) return PORT_XP;
        if (dst_x < cur_x) return PORT_XM;
        if (dst_y > cur_y) return PORT_YP;
        if (dst_y < cur_y) return PORT_YM;
        return PORT_LOCAL;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, search starts at ptr.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-output wormhole lock plus round-robin head arbitration,
// grants issued combinationally in the request cycle.
module switch_allocator #(
    parameter int X_SIZE    = 4,
    parameter int Y_SIZE    = 4,
    parameter int NUM_PORTS = noc_pkg::NUM_PORTS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [$clog2(X_SIZE)-1:0]                 my_x,
    input  logic [$clog2(Y_SIZE)-1:0]                 my_y,
    input  logic [NUM_PORTS-1:0]                      in_valid,
    input  logic [NUM_PORTS-1:0][1:0]                 in_type,
    input  logic [NUM_PORTS-1:0][$clog2(X_SIZE)-1:0]  in_dst_x,
    input  logic [NUM_PORTS-1:0][$clog2(Y_SIZE)-1:0]  in_dst_y,
    input  logic [NUM_PORTS-1:0]                      out_ready,
    output logic [NUM_PORTS-1:0]                      in_grant,
    output logic [NUM_PORTS-1:0]                      out_valid,
    output logic [NUM_PORTS-1:0][2:0]                 xbar_sel,
    output logic                                      err_orphan
);

    import noc_pkg::*;

    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]                route_vld;
    logic [NUM_PORTS-1:0][2:0]           route_port;
    logic [NUM_PORTS-1:0]                out_lock;
    logic [NUM_PORTS-1:0][2:0]           out_owner;
    logic [NUM_PORTS-1:0][PW-1:0]        rr_ptr;

    logic [NUM_PORTS-1:0][2:0]           hroute;
    logic [NUM_PORTS-1:0]                is_hdr;
    logic [NUM_PORTS-1:0]                is_cont;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] arb_req;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] arb_gnt;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            hroute[i]  = xy_route(int'(in_dst_x[i]), int'(in_dst_y[i]),
                                  int'(my_x), int'(my_y));
            is_hdr[i]  = (in_type[i] == FLIT_HEAD) ||
                         (in_type[i] == FLIT_SINGLE);
            is_cont[i] = (in_type[i] == FLIT_BODY) ||
                         (in_type[i] == FLIT_TAIL);
        end
    end

    // Heads with a live route are mid-packet protocol errors; keep them out.
    always_comb begin
        arb_req = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                arb_req[o][i] = !rst && in_valid[i] && is_hdr[i] &&
                                !route_vld[i] && (hroute[i] == 3'(o)) &&
                                !out_lock[o] && out_ready[o];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter #(
            .N  (NUM_PORTS),
            .PW (PW)
        ) u_arb (
            .req (arb_req[o]),
            .ptr (rr_ptr[o]),
            .gnt (arb_gnt[o])
        );
    end

    always_comb begin
        gnt = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (out_lock[o]) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    gnt[o][i] = !rst && (out_owner[o] == 3'(i)) &&
                                in_valid[i] && out_ready[o] && is_cont[i] &&
                                route_vld[i] && (route_port[i] == 3'(o));
                end
            end else begin
                gnt[o] = arb_gnt[o];
            end
        end
    end

    always_comb begin
        in_grant   = '0;
        out_valid  = '0;
        xbar_sel   = '0;
        err_orphan = 1'b0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt[o][i]) begin
                    in_grant[i] = 1'b1;
                    out_valid[o] = 1'b1;
                    xbar_sel[o] = 3'(i);
                end
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!rst && in_valid[i] && is_cont[i] && !route_vld[i])
                err_orphan = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            route_vld  <= '0;
            route_port <= '0;
            out_lock   <= '0;
            out_owner  <= '0;
            rr_ptr     <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (gnt[o][i]) begin
                        if (in_type[i] == FLIT_HEAD) begin
                            out_lock[o]   <= 1'b1;
                            out_owner[o]  <= 3'(i);
                            route_vld[i]  <= 1'b1;
                            route_port[i] <= 3'(o);
                        end
                        if (in_type[i] == FLIT_TAIL) begin
                            out_lock[o]  <= 1'b0;
                            route_vld[i] <= 1'b0;
                        end
                        if (in_type[i] == FLIT_TAIL ||
                            in_type[i] == FLIT_SINGLE) begin
                            rr_ptr[o] <= (i == NUM_PORTS - 1) ?
                                         '0 : PW'(i + 1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter X_SIZE, default 4, mesh columns.
REQ-002 Parameter Y_SIZE, default 4, mesh rows.
REQ-003 Parameter NUM_PORTS, default 5, router ports (0 LOCAL, 1 XP, 2 XM, 3 YP, 4 YM).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 my_x  input  $clog2(X_SIZE)  this router's column; quasi-static.
REQ-007 my_y  input  $clog2(Y_SIZE)  this router's row; quasi-static.
REQ-008 in_valid  input  [NUM_PORTS]  input FIFO head flit valid, per input port.
REQ-009 in_type  input  [NUM_PORTS][2]  head flit type (00 HEAD, 01 BODY, 10 TAIL, 11 SINGLE).
REQ-010 in_dst_x / in_dst_y  input  [NUM_PORTS][$clog2(X_SIZE)] / [$clog2(Y_SIZE)]  destination; meaningful only on HEAD/SINGLE.
REQ-011 out_ready  input  [NUM_PORTS]  downstream can accept a flit, per output port.
REQ-012 in_grant  output  [NUM_PORTS]  input flit consumed this cycle (pop FIFO).
REQ-013 out_valid  output  [NUM_PORTS]  output port driven this cycle.
REQ-014 xbar_sel  output  [NUM_PORTS][3]  input index routed to each output; 0 when out_valid low.
REQ-015 err_orphan  output  1  one-cycle pulse: BODY/TAIL presented on an input with no locked route.

Function
REQ-016 Route SHALL be XY: dst_x>my_x XP; dst_x<my_x XM; else dst_y>my_y YP; dst_y<my_y YM; else LOCAL.
REQ-017 Each output SHALL hold state IDLE or LOCKED(owner); each input SHALL hold a registered route (valid bit + 3-bit port).
REQ-018 Grant SHALL be combinational, same cycle as request: in_grant[i] = out_valid[o] = 1 and xbar_sel[o] = i.
REQ-019 IDLE output SHALL arbitrate among inputs with in_valid, type HEAD/SINGLE and XY route = o, only when out_ready[o]=1.
REQ-020 Arbitration SHALL be round-robin per output, priority starting at rr_ptr[o]; after any grant completing a packet, rr_ptr[o] = winner+1 mod NUM_PORTS.
REQ-021 Granted HEAD SHALL move output to LOCKED(i) and latch input route i next edge; SINGLE SHALL leave output IDLE and no route latched.
REQ-022 LOCKED(i) output SHALL grant only input i, only when in_valid[i] and out_ready[o]; other requesters wait.
REQ-023 Granted TAIL SHALL return output to IDLE and clear input route next edge; new HEAD on that output is grantable earliest the following cycle.
REQ-024 out_ready[o]=0 SHALL suppress any grant to o; state unchanged (stall, no flit lost).
REQ-025 HEAD on input with valid route, or BODY/TAIL on input without one, SHALL not be granted; BODY/TAIL case pulses err_orphan.
REQ-026 Each input SHALL receive at most one grant per cycle; each output drives at most one input per cycle.
REQ-027 U-turn (route to own input port, non-LOCAL) SHALL be impossible under XY and needs no handling.

Reset
REQ-028 On rst: all outputs IDLE, all input routes invalid, rr_ptr = 0, in_grant/out_valid/xbar_sel/err_orphan = 0 that cycle.
REQ-029 rst mid-packet SHALL abandon locks; subsequent BODY/TAIL flits flag err_orphan.

Structure
REQ-030 noc_pkg SHALL hold port index enum, flit type enum, NUM_PORTS, and xy_route function.
REQ-031 One sub-module rr_arbiter (NUM_PORTS requests, pointer in, one-hot grant out) instantiated per output.

Verification
REQ-032 my=(1,1); input LOCAL SINGLE dst (3,1), out_ready all 1 -> same-cycle in_grant[0], out_valid[1], xbar_sel[1]=0.
REQ-033 Inputs XM and YM both HEAD to XP, rr_ptr=0 -> XM wins, 3-flit packet streams uninterrupted, YM granted cycle after TAIL.
REQ-034 Locked XP packet, out_ready[1] low 3 cycles -> no grants those cycles, BODY resumes on ready, packet intact.
REQ-035 Two inputs repeatedly sending SINGLE to LOCAL -> grants alternate every cycle.
REQ-036 BODY on input YP after reset -> no grant, err_orphan=1 one cycle.
REQ-037 rst asserted mid-packet -> next cycle all outputs 0, output unlocked, fresh HEAD granted.
